// File: rtl/rv32i_types.sv
// Shared types for the burst-memory arbiter: FSM states, port owner and line geometry.
package rv32i_types;

  localparam int unsigned BEATS_PER_LINE = 4;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdWait,
    StWrBurst,
    StResp
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/line_assembler.sv
// Beat counter plus indexed line register: packs read beats into a cacheline and
// supplies the beat index used to slice write beats out of a latched line.
module line_assembler
  import rv32i_types::*;
#(
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned LINE_W = BEAT_W * BEATS_PER_LINE,
  localparam int unsigned CntW = $clog2(BEATS_PER_LINE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              capture,
  input  logic [BEAT_W-1:0] beat_in,
  output logic [CntW-1:0]   cnt,
  output logic              done,
  output logic [LINE_W-1:0] line_out
);

  localparam logic [CntW-1:0] LastBeat = CntW'(BEATS_PER_LINE - 1);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt      <= '0;
      line_out <= '0;
    end else begin
      if (step) begin
        cnt <= cnt + 1'b1;
      end
      if (capture) begin
        line_out[int'(cnt) * BEAT_W +: BEAT_W] <= beat_in;
      end
    end
  end

  assign done = step && (cnt == LastBeat);

endmodule

// File: rtl/bmem_arbiter.sv
// Shares the 64-bit burst memory port between I-cache and D-cache line requests.
// Define BMEM_ARB_RR_EN for round-robin arbitration; default is fixed D-over-I priority.
module bmem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  input  logic              bmem_ready,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_rvalid,
  input  logic [BEAT_W-1:0] bmem_rdata
);

  localparam int unsigned CntW = $clog2(BEATS_PER_LINE);
  localparam logic [ADDR_W-1:0] OffMask = ADDR_W'(LINE_W / 8 - 1);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, grant_owner;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              grant;
  logic              step, capture, done;
  logic [CntW-1:0]   cnt;
  logic [LINE_W-1:0] line;

  assign grant = (state_q == StIdle) && (i_req || d_req);

`ifdef BMEM_ARB_RR_EN
  arb_owner_t last_q;

  // On conflict the requester that did not win last time goes first.
  always_comb begin
    if (i_req && d_req) begin
      grant_owner = (last_q == OWN_D) ? OWN_I : OWN_D;
    end else begin
      grant_owner = d_req ? OWN_D : OWN_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= OWN_D;
    end else if (grant) begin
      last_q <= grant_owner;
    end
  end
`else
  always_comb begin
    grant_owner = d_req ? OWN_D : OWN_I;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= OWN_D;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_q <= grant_owner;
        addr_q  <= ((grant_owner == OWN_D) ? d_addr : i_addr) & ~OffMask;
        wdata_q <= d_wdata;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    step       = 1'b0;
    capture    = 1'b0;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = ((grant_owner == OWN_D) && d_we) ? StWrBurst : StRdIssue;
        end
      end
      StRdIssue: begin
        bmem_read = bmem_ready;
        if (bmem_ready) begin
          state_d = StRdWait;
        end
      end
      StRdWait: begin
        step    = bmem_rvalid;
        capture = bmem_rvalid;
        if (done) begin
          state_d = StResp;
        end
      end
      StWrBurst: begin
        // Only the first beat waits for ready; the rest stream back-to-back.
        bmem_write = (cnt == '0) ? bmem_ready : 1'b1;
        step       = bmem_write;
        if (done) begin
          state_d = StResp;
        end
      end
      StResp: begin
        i_resp  = (owner_q == OWN_I);
        d_resp  = (owner_q == OWN_D);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  line_assembler #(
    .BEAT_W(BEAT_W),
    .LINE_W(LINE_W)
  ) u_line (
    .clk     (clk),
    .rst     (rst),
    .load    (grant),
    .step    (step),
    .capture (capture),
    .beat_in (bmem_rdata),
    .cnt     (cnt),
    .done    (done),
    .line_out(line)
  );

  assign bmem_addr  = (state_q inside {StRdIssue, StRdWait, StWrBurst}) ? addr_q : '0;
  assign bmem_wdata = bmem_write ? wdata_q[int'(cnt) * BEAT_W +: BEAT_W] : '0;
  assign i_rdata    = (owner_q == OWN_I) ? line : '0;
  assign d_rdata    = (owner_q == OWN_D) ? line : '0;

  always_ff @(posedge clk) begin
    if (!rst && state_q != StIdle) begin
      assert ((owner_q == OWN_I) ? i_req : d_req);
    end
    if (!rst) begin
      assert (!(bmem_rvalid && state_q != StRdWait));
    end
  end

endmodule

// File: tb/tb_bmem_arbiter.sv
// Scoreboard bench for bmem_arbiter: directed requests push expectations, a monitor checks them.
module tb_bmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_req, i_resp, d_req, d_we, d_resp;
  logic [31:0]  i_addr, d_addr, bmem_addr;
  logic [255:0] i_rdata, d_rdata, d_wdata;
  logic         bmem_ready, bmem_read, bmem_write, bmem_rvalid;
  logic [63:0]  bmem_wdata, bmem_rdata;

  always #5 clk = ~clk;

  bmem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_resp     (i_resp),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_resp     (d_resp),
    .bmem_ready (bmem_ready),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_rvalid(bmem_rvalid),
    .bmem_rdata (bmem_rdata)
  );

  typedef struct {
    bit           is_i;
    bit           chk_data;
    logic [255:0] data;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } wr_t;

  resp_t       exp_resp[$];
  logic [31:0] exp_rd[$];
  wr_t         exp_wr[$];
  logic [63:0] rbeats[$];
  int          rgaps[$];
  int          stall_q[$];
  string       tmo_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_resp_cyc = 0;
  int last_wr_cyc   = 0;
  int wr_run        = 0;
  bit chk_zero = 0;
  bit gap_chk  = 0;
  bit done     = 0;

  localparam logic [255:0] WLINE = {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                                    64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    resp_t e;
    wr_t   w;
    if (tmo_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout %s: got no response, expected one within bound", tmo_q.pop_front());
    end
    if (done) begin
      chk("resp_queue_drained", 256'(exp_resp.size()), 256'd0);
      chk("read_queue_drained", 256'(exp_rd.size()), 256'd0);
      chk("write_queue_drained", 256'(exp_wr.size()), 256'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end else begin
      if (chk_zero) begin
        chk("zero_i_rdata", i_rdata, 256'd0);
        chk("zero_d_rdata", d_rdata, 256'd0);
        chk("zero_ctrl", {i_resp, d_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata}, 256'd0);
      end
      if (i_resp || d_resp) begin
        last_resp_cyc = cyc;
        if (exp_resp.size() == 0) begin
          chk("resp_unexpected", {i_resp, d_resp}, 256'd0);
        end else begin
          e = exp_resp.pop_front();
          chk("resp_owner", {i_resp, d_resp}, e.is_i ? 256'd2 : 256'd1);
          if (e.chk_data) chk("resp_rdata", e.is_i ? i_rdata : d_rdata, e.data);
        end
      end
      if (bmem_read) begin
        if (exp_rd.size() == 0) chk("read_unexpected", bmem_read, 256'd0);
        else chk("read_addr", bmem_addr, exp_rd.pop_front());
        if (gap_chk) chk("b2b_resp_to_read_cycles", 256'(cyc - last_resp_cyc), 256'd2);
      end
      if (bmem_write) begin
        if (exp_wr.size() == 0) begin
          chk("write_unexpected", bmem_write, 256'd0);
        end else begin
          w = exp_wr.pop_front();
          chk("write_addr", bmem_addr, w.addr);
          chk("write_beat", bmem_wdata, w.data);
        end
        if (wr_run > 0) chk("write_consecutive", 256'(cyc - last_wr_cyc), 256'd1);
        wr_run      = (wr_run + 1) % 4;
        last_wr_cyc = cyc;
      end
    end
  end

  // Memory responder: ready stalls and read beats with programmed gaps
  initial begin
    int   stall, left, gap;
    logic acc;
    stall = 0; left = 0; gap = 0;
    bmem_ready = 1'b1; bmem_rvalid = 1'b0; bmem_rdata = '0;
    forever begin
      @(negedge clk);
      acc = bmem_read;
      @(posedge clk);
      #1;
      bmem_rvalid = 1'b0;
      bmem_rdata  = '0;
      if (rst) begin
        left = 0; stall = 0; acc = 1'b0;
        rbeats.delete();
        rgaps.delete();
      end
      if (stall_q.size() > 0) stall = stall_q.pop_front();
      if (stall > 0) begin
        bmem_ready = 1'b0;
        stall--;
      end else begin
        bmem_ready = 1'b1;
      end
      if (acc) begin
        left = 4;
        gap  = rgaps.pop_front();
      end
      if (left > 0) begin
        if (gap > 0) begin
          gap--;
        end else begin
          bmem_rvalid = 1'b1;
          bmem_rdata  = rbeats.pop_front();
          left--;
          if (left > 0) gap = rgaps.pop_front();
        end
      end
    end
  end

  task automatic prep_read(input bit is_i, input logic [31:0] addr,
                           input logic [63:0] b0, input logic [63:0] b1,
                           input logic [63:0] b2, input logic [63:0] b3,
                           input int g1, input int g2, input int g3, input bit want_resp);
    rbeats.push_back(b0); rbeats.push_back(b1); rbeats.push_back(b2); rbeats.push_back(b3);
    rgaps.push_back(0); rgaps.push_back(g1); rgaps.push_back(g2); rgaps.push_back(g3);
    exp_rd.push_back(addr & ~32'h1f);
    if (want_resp) exp_resp.push_back(resp_t'{is_i, 1'b1, {b3, b2, b1, b0}});
  endtask

  task automatic prep_write(input logic [31:0] addr, input logic [255:0] line);
    for (int k = 0; k < 4; k++) exp_wr.push_back(wr_t'{addr & ~32'h1f, line[64*k +: 64]});
    exp_resp.push_back(resp_t'{1'b0, 1'b0, 256'd0});
  endtask

  task automatic wait_resp(input bit is_i, input string name);
    bit got = 0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (is_i ? i_resp : d_resp) got = 1;
    end
    if (!got) tmo_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic run_i(input logic [31:0] addr);
    i_addr = addr;
    i_req  = 1'b1;
    wait_resp(1'b1, "i_resp");
    i_req  = 1'b0;
  endtask

  task automatic run_d(input bit we, input logic [31:0] addr, input logic [255:0] line);
    d_we    = we;
    d_addr  = addr;
    d_wdata = line;
    d_req   = 1'b1;
    wait_resp(1'b0, "d_resp");
    d_req   = 1'b0;
    d_we    = 1'b0;
  endtask

  initial begin
    int nbeats;
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    #1 chk_zero = 1'b1;
    @(posedge clk);
    #1 chk_zero = 1'b0;
    rst = 1'b0;

    // I-cache read, no stalls
    prep_read(1'b1, 32'h1000, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 0, 0, 0, 1'b1);
    run_i(32'h1000);

    // D writeback with ready low at the start of the burst
    stall_q.push_back(2);
    prep_write(32'h2004, WLINE);
    run_d(1'b1, 32'h2004, WLINE);

    // Conflicting requests; the previous grant went to D
`ifdef BMEM_ARB_RR_EN
    prep_read(1'b1, 32'h4000, 64'h4A, 64'h4B, 64'h4C, 64'h4D, 0, 1, 0, 1'b1);
    prep_read(1'b0, 32'h3000, 64'h3A, 64'h3B, 64'h3C, 64'h3D, 0, 0, 2, 1'b1);
`else
    prep_read(1'b0, 32'h3000, 64'h3A, 64'h3B, 64'h3C, 64'h3D, 0, 0, 2, 1'b1);
    prep_read(1'b1, 32'h4000, 64'h4A, 64'h4B, 64'h4C, 64'h4D, 0, 1, 0, 1'b1);
`endif
    fork
      run_i(32'h4000);
      run_d(1'b0, 32'h3000, 256'd0);
    join

    // Ready stall during issue and a gap in the beat stream
    stall_q.push_back(6);
    prep_read(1'b1, 32'h6040, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0, 0, 3, 0, 1'b1);
    run_i(32'h6040);

    // Reset in the middle of a read: partial line dropped, no response
    prep_read(1'b1, 32'h7000, 64'hDEAD_0000, 64'hDEAD_0001, 64'hDEAD_0002, 64'hDEAD_0003,
              0, 5, 5, 1'b0);
    i_addr = 32'h7000;
    i_req  = 1'b1;
    nbeats = 0;
    for (int k = 0; k < 100 && nbeats < 2; k++) begin
      @(negedge clk);
      if (bmem_rvalid) nbeats++;
    end
    if (nbeats < 2) tmo_q.push_back("abort_beats");
    @(posedge clk);
    #1 rst = 1'b1;
    i_req = 1'b0;
    @(posedge clk);
    #1 chk_zero = 1'b1;
    @(posedge clk);
    #1 chk_zero = 1'b0;
    rst = 1'b0;
    prep_read(1'b1, 32'h7000, 64'h7777_0000, 64'h7777_1111, 64'h7777_2222, 64'h7777_3333,
              0, 0, 0, 1'b1);
    run_i(32'h7000);

    // Back-to-back D reads: one idle bubble between response and next read command
    prep_read(1'b0, 32'h5000, 64'h50, 64'h51, 64'h52, 64'h53, 0, 0, 0, 1'b1);
    run_d(1'b0, 32'h5000, 256'd0);
    gap_chk = 1'b1;
    prep_read(1'b0, 32'h5020, 64'h60, 64'h61, 64'h62, 64'h63, 0, 0, 0, 1'b1);
    run_d(1'b0, 32'h5020, 256'd0);
    gap_chk = 1'b0;

    repeat (3) @(posedge clk);
    #1 done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

endmodule
